// File: rtl/node_pkg.sv
// ============================================================================
// node_pkg -- node word layout, loader FSM states and beat-count helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package node_pkg;

    typedef struct packed {
        logic        is_leaf;
        logic [6:0]  class_id;
        logic [7:0]  feature;
        logic [31:0] threshold;
        logic [15:0] left;
        logic [15:0] right;
    } node_s;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } load_state_e;

    function automatic int beats_per_node(input int node_bits, input int beat_w);
        return (node_bits + beat_w - 1) / beat_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tree_constants.sv
// ============================================================================
// tree_constants -- sizing constants shared by the tree classifier and loader
// Revision: 1.0
// ============================================================================
`default_nettype none

package tree_constants;
    localparam int TOTAL_NODES = 15;
endpackage

`default_nettype wire

// File: rtl/node_loader.sv
// ============================================================================
// node_loader -- assembles serialized beats into node words and writes them
//                into the classifier's node memory, with framing checks.
// Revision: 1.0
// ============================================================================
`default_nettype none

module node_loader
    import node_pkg::*;
#(
    parameter int BEAT_W    = 32,
    parameter int NODE_BITS = $bits(node_s),
    parameter int N_NODES   = tree_constants::TOTAL_NODES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BEAT_W-1:0]    in_data,
    input  logic                 in_last,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [NODE_BITS-1:0] mem_wdata,
    output logic [31:0]          node_count,
    output logic                 done,
    output logic                 error
);

    localparam int                BPN       = beats_per_node(NODE_BITS, BEAT_W);
    localparam int                CNT_W     = (BPN > 1) ? $clog2(BPN) : 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BPN - 1);
    localparam logic [31:0]       LAST_NODE = 32'(N_NODES - 1);

    load_state_e          state_q, state_d;
    logic [CNT_W-1:0]     beat_q, beat_d;
    logic [NODE_BITS-1:0] asm_q, asm_d;
    logic [31:0]          count_q, count_d;
    logic                 ready_q, ready_d;
    logic                 we_q, we_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;

    logic accept;
    logic is_final;

    assign accept   = ready_q & in_valid;
    assign is_final = (beat_q == LAST_BEAT) && (count_q == LAST_NODE);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        asm_d   = asm_q;
        count_d = count_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                    beat_d  = '0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    // Bits of the final beat beyond NODE_BITS simply have no destination.
                    for (int i = 0; i < NODE_BITS; i++) begin
                        if (beat_q == CNT_W'(i / BEAT_W)) begin
                            asm_d[i] = in_data[i % BEAT_W];
                        end
                    end
                    // in_last must coincide exactly with the last beat of the last node.
                    if (in_last != is_final) begin
                        state_d = ST_ERR;
                        beat_d  = '0;
                    end else if (beat_q == LAST_BEAT) begin
                        state_d = ST_WRITE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                count_d = count_q + 32'd1;
                state_d = (count_q == LAST_NODE) ? ST_DONE : ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_LOAD);
        we_d    = (state_d == ST_WRITE);
        done_d  = (state_d == ST_DONE);
        error_d = (state_d == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            asm_q   <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            asm_q   <= asm_d;
            count_q <= count_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign in_ready   = ready_q;
    assign mem_we     = we_q;
    assign mem_addr   = count_q;
    assign mem_wdata  = asm_q;
    assign node_count = count_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

`default_nettype wire

// File: doc/node_loader.md
NODE_LOADER -- requirements
Module: node_loader

Interface
REQ-001 The module SHALL have parameter BEAT_W, default 32, giving the input beat width in bits.
REQ-002 The module SHALL have parameter NODE_BITS, default $bits(node_s), giving the node word width.
REQ-003 The module SHALL have parameter N_NODES, default TOTAL_NODES, giving the number of nodes in one tree image.
REQ-004 Port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 Port start, input, 1 bit: single-cycle pulse that begins a load.
REQ-007 Port in_valid, input, 1 bit: beat on in_data is valid.
REQ-008 Port in_ready, output, 1 bit: loader accepts a beat this cycle.
REQ-009 Port in_data, input, BEAT_W bits: serialized node image beat.
REQ-010 Port in_last, input, 1 bit: marks the final beat of the whole image.
REQ-011 Port mem_we, output, 1 bit: node memory write strobe.
REQ-012 Port mem_addr, output, 32 bits: node index being written.
REQ-013 Port mem_wdata, output, NODE_BITS bits: assembled node_s word.
REQ-014 Port node_count, output, 32 bits: number of nodes written so far.
REQ-015 Port done, output, 1 bit: image loaded successfully (sticky).
REQ-016 Port error, output, 1 bit: framing error detected (sticky).

Function
REQ-017 BPN (beats per node) SHALL equal ceil(NODE_BITS/BEAT_W).
REQ-018 The FSM SHALL have states IDLE, LOAD, WRITE, DONE and ERR.
REQ-019 In IDLE, start=1 SHALL clear node_count and the beat counter and go to LOAD; all other inputs are ignored.
REQ-020 in_ready SHALL be 1 only in LOAD; a beat is accepted on any cycle with in_valid=1 and in_ready=1.
REQ-021 Accepted beat k (0..BPN-1) of a node SHALL be placed at bits [k*BEAT_W +: BEAT_W], least-significant beat first; bits at or above NODE_BITS SHALL be discarded.
REQ-022 After beat BPN-1 is accepted, the FSM SHALL enter WRITE on the next cycle.
REQ-023 WRITE SHALL last exactly one cycle with mem_we=1, mem_addr=node_count and mem_wdata=the assembled word.
REQ-024 node_count SHALL increment on the cycle after the WRITE cycle.
REQ-025 From WRITE, the FSM SHALL go to DONE if mem_addr==N_NODES-1, else to LOAD.
REQ-026 in_last=1 on an accepted beat SHALL be legal only on beat BPN-1 of node N_NODES-1.
REQ-027 in_last=1 on any other accepted beat SHALL send the FSM to ERR on the next cycle, with no WRITE for the partial node.
REQ-028 An accepted beat BPN-1 of node N_NODES-1 with in_last=0 SHALL also send the FSM to ERR, with no WRITE.
REQ-029 mem_we SHALL be 0 outside WRITE; mem_addr and mem_wdata are don't-care when mem_we=0.
REQ-030 done=1 only in DONE and error=1 only in ERR; DONE and ERR SHALL hold with in_ready=0 until start or reset.
REQ-031 start in DONE or ERR SHALL behave as in IDLE; start in LOAD or WRITE SHALL be ignored.
REQ-032 in_valid with in_ready=0 SHALL have no effect.
REQ-033 Throughput SHALL be BPN+1 cycles per node with in_valid held high.

Reset
REQ-034 With reset=0 at a clock edge: state=IDLE, node_count=0, beat counter=0, assembly register=0, and in_ready, mem_we, done and error all 0.
REQ-035 A reset mid-load SHALL abandon the partial node, and no further write SHALL occur.

Structure
REQ-036 The FSM state enum and the BPN function SHALL live in node_pkg beside node_s; N_NODES SHALL come from tree_constants.
REQ-037 No sub-module is needed; assembly, counter and FSM SHALL be one module.
REQ-038 mem_* SHALL match the write port of the node_data memory that classifier reads, so a loaded image replaces $readmemb of nodes.txt.

Verification (bench uses NODE_BITS=80, BEAT_W=32, N_NODES=2, so BPN=3)
REQ-039 Scenario: reset, start, then beats 0x11111111, 0x22222222, 0xFFFFABCD -> one cycle after beat 3: mem_we=1, mem_addr=0, mem_wdata=80'hABCD_22222222_11111111.
REQ-040 Scenario: 6 back-to-back beats, in_last on beat 6 -> writes to addresses 0 and 1 on cycles 4 and 8, done=1 on cycle 9, node_count=2.
REQ-041 Scenario: in_last on beat 2 -> error=1 on the next cycle, no mem_we pulse, node_count=0.
REQ-042 Scenario: 6 beats without in_last -> one write at address 0, then error=1, node_count=1.
REQ-043 Scenario: in_valid toggled 1-0-1 each cycle -> the same mem_wdata as REQ-039, and in_ready=0 during WRITE.
REQ-044 Scenario: reset=0 after beat 2, then start and 3 fresh beats -> the first write is at mem_addr=0 with the fresh data only.
